// File: rtl/rej_sample_56_pkg.sv
// Raccoon shared parameters: modulus Q, coefficient/input widths, default
// polynomial length, control FSM state encoding and the rejection compare.
// No logic, no latency, no flow control.
package rej_sample_56_pkg;

  localparam int unsigned COEF_W     = 49;
  localparam int unsigned DIN_W      = 56;
  localparam int unsigned N_COEF_DEF = 512;

  // Q = (2^24 - 2^18 + 1) * (2^25 - 2^18 + 1)
  localparam logic [COEF_W-1:0] Q = 49'd549824583172097;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic below_q(input logic [COEF_W-1:0] c);
    return c < Q;
  endfunction

endpackage

// File: rtl/rej_sample_56_if.sv
// Handshake bundle between the width converter / consumer and the sampler.
// Pure wiring, zero latency.
// Din side has no backpressure; Dout side is valid/ready (D_flag/out_ready).
//   slave  : the sampler (takes start/inflag/Din/out_ready, drives the rest)
//   master : the environment driving the sampler
interface rej_sample_56_if;
  import rej_sample_56_pkg::*;

  logic              start;
  logic              inflag;
  logic [DIN_W-1:0]  Din;
  logic              out_ready;
  logic [COEF_W-1:0] Dout;
  logic              D_flag;
  logic              done;
  logic              overflow;

  modport master (
    output start, inflag, Din, out_ready,
    input  Dout, D_flag, done, overflow
  );

  modport slave (
    input  start, inflag, Din, out_ready,
    output Dout, D_flag, done, overflow
  );
endinterface

// File: rtl/rej_sample_56_fifo.sv
// sync_fifo_fwft: first-word-fall-through buffer with synchronous flush.
// Latency: a push is visible on dout_o/empty_o the cycle after the push edge.
// Backpressure: push while full is refused unless a pop happens the same cycle.
//   clk, rst (async active-low); flush_i clears contents; push_i/din_i write;
//   pop_i reads head; dout_o head word; full_o/empty_o occupancy flags.
module sync_fifo_fwft #(
  parameter int unsigned W     = 49,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  // Popping frees a slot in the same cycle, so a full FIFO can still take a push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: stale words are never visible while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/rej_sample_56.sv
// Rejection sampler: keeps 49-bit candidates below Q, emits N_COEF per start.
// Latency: inflag -> D_flag is 2 cycles when the output FIFO is empty.
// Backpressure: none upstream; out_ready stalls the FIFO, overflow drops are sticky.
//   clk, rst (async active-low); bus.start/inflag/Din in; bus.out_ready in;
//   bus.Dout/D_flag out (valid/ready); bus.done while finished; bus.overflow sticky.
module rej_sample_56
  import rej_sample_56_pkg::*;
#(
  parameter int unsigned N_COEF     = N_COEF_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  rej_sample_56_if.slave  bus
);
  localparam int unsigned CW = $clog2(N_COEF) + 1;
  localparam logic [CW-1:0] N_C = CW'(N_COEF);

  state_e            state_q, state_d;
  logic              stg_vld_q, stg_vld_d;
  logic [COEF_W-1:0] stg_dat_q, stg_dat_d;
  logic [CW-1:0]     acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic              ovf_q, ovf_d;

  logic [COEF_W-1:0] cand;
  logic              accept;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [COEF_W-1:0] fifo_dout;
  logic              unused_din_hi;

  // Only the low 49 bits of each converter word form the candidate.
  assign cand          = bus.Din[COEF_W-1:0];
  assign unused_din_hi = ^bus.Din[DIN_W-1:COEF_W];

  assign accept = (state_q == ST_RUN) && bus.inflag && below_q(cand)
                  && (acc_cnt_q < N_C);
  assign pop    = ~fifo_empty & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    stg_vld_d = 1'b0;
    stg_dat_d = cand;
    acc_cnt_d = acc_cnt_q;
    out_cnt_d = out_cnt_q;
    ovf_d     = ovf_q;
    if (bus.start) begin
      // start wins over everything: the staged word and this cycle's input die.
      state_d   = ST_RUN;
      acc_cnt_d = '0;
      out_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (accept) begin
        stg_vld_d = 1'b1;
        acc_cnt_d = acc_cnt_q + CW'(1);
      end
      if (pop && (out_cnt_q < N_C)) out_cnt_d = out_cnt_q + CW'(1);
      if (stg_vld_q && fifo_full && !pop) ovf_d = 1'b1;
      if ((state_q == ST_RUN) && (out_cnt_d == N_C)) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      stg_vld_q <= 1'b0;
      stg_dat_q <= '0;
      acc_cnt_q <= '0;
      out_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stg_vld_q <= stg_vld_d;
      stg_dat_q <= stg_dat_d;
      acc_cnt_q <= acc_cnt_d;
      out_cnt_q <= out_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  sync_fifo_fwft #(
    .W     (COEF_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.start),
    .push_i  (stg_vld_q),
    .din_i   (stg_dat_q),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.D_flag   = ~fifo_empty;
  assign bus.Dout     = fifo_empty ? '0 : fifo_dout;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.overflow = ovf_q;
endmodule

// File: doc/rej_sample_56.md
REJ_SAMPLE_56 -- requirements
Module: rej_sample_56

Interface
REQ-001 Parameter N_COEF, default 512, coefficients emitted per polynomial.
REQ-002 Parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a new polynomial.
REQ-006 inflag  input  1  Din valid; no backpressure is available upstream.
REQ-007 Din  input  56  candidate word from the 64-to-56 width converter.
REQ-008 out_ready  input  1  consumer accepts Dout this cycle.
REQ-009 Dout  output  49  accepted coefficient, value < Q.
REQ-010 D_flag  output  1  Dout valid.
REQ-011 done  output  1  high while in DONE.
REQ-012 overflow  output  1  sticky; an accepted sample was dropped.

Function
REQ-013 Q shall be 549824583172097, i.e. (2^24-2^18+1)*(2^25-2^18+1), 49 bits.
REQ-014 The candidate shall be Din[48:0]; Din[55:49] are discarded.
REQ-015 A candidate is accepted iff inflag=1, state=RUN, candidate < Q (unsigned, strict), and acc_cnt < N_COEF.
REQ-016 States: IDLE, RUN, DONE. IDLE->RUN on start. RUN->DONE when out_cnt reaches N_COEF. DONE->RUN on start.
REQ-017 start in any state shall flush the FIFO and stage register, clear acc_cnt, out_cnt and overflow, and enter RUN next cycle.
REQ-018 inflag outside RUN, or in the start cycle, shall be ignored.
REQ-019 Stage 1 shall register the compare result and candidate. Stage 2 shall push into the FIFO. Latency inflag to D_flag shall be 2 cycles with the FIFO empty.
REQ-020 acc_cnt shall increment on each stage-1 acceptance. Candidates after acc_cnt=N_COEF shall be discarded without setting overflow.
REQ-021 The FIFO shall be first-word-fall-through. D_flag = not empty. A pop occurs when D_flag & out_ready.
REQ-022 out_cnt shall increment on each pop.
REQ-023 A push with the FIFO full and no same-cycle pop shall drop the sample and set overflow. A push and pop in the same cycle when full shall both succeed.
REQ-024 Dout shall hold its value while D_flag=1 and out_ready=0. Dout shall be 0 when D_flag=0.
REQ-025 Counters shall be clog2(N_COEF)+1 bits and never wrap; the FIFO pointers shall wrap modulo FIFO_DEPTH.

Reset
REQ-026 On rst=0, asynchronously: state=IDLE, FIFO empty, counters=0, stage valid=0.
REQ-027 On rst=0, outputs shall be Dout=0, D_flag=0, done=0, overflow=0.
REQ-028 Reset mid-polynomial shall discard all buffered data. No output shall occur until the next start.

Structure
REQ-029 Q, its width (49) and N_COEF default shall reside in the shared Raccoon parameters package.
REQ-030 The FIFO shall be a sub-module named sync_fifo_fwft, parameterised by width and depth, with full/empty flags.
REQ-031 Control FSM, compare stage and counters shall reside in rej_sample_56.

Verification
REQ-032 start; Din=Q-1 with inflag for 1 cycle, out_ready=1 -> D_flag=1 two cycles later, Dout=549824583172096.
REQ-033 Din=Q, then Din=2^49-1 -> no D_flag. Then Din={7'h7F, 49'd5} -> Dout=5 (upper bits discarded).
REQ-034 N_COEF=8; 10 valid words, out_ready=1 -> exactly 8 pops, done=1, overflow=0, last two discarded.
REQ-035 out_ready=0; 6 accepted words, FIFO_DEPTH=4 -> overflow=1. Then out_ready=1 -> first 4 values popped in order.
REQ-036 Full FIFO, out_ready=1, accepted push every cycle -> no overflow, continuous D_flag.
REQ-037 rst=0 mid-RUN with 3 entries buffered -> D_flag=0 immediately. Inflag without start -> no output. start -> normal operation.
